// File: rtl/seg_scan_driver.sv
// Time-multiplexed 7-segment scan driver: latches a frame snapshot of a static segment bus and scans it digit by digit.
// Optional overflow blink is enabled by defining SEG_SCAN_OVF_BLINK_EN. Segment bit i is segment a+i (a at bit 0).
module seg_scan_driver #(
  parameter int N_SEGS   = 8,
  parameter int DIV_W    = 16,
  parameter int DIV_TERM = 49999
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7*N_SEGS-1:0]   segs_in,
  input  logic                  overflow,
  output logic [6:0]            seg_out,
  output logic [N_SEGS-1:0]     an_out,
  output logic                  frame_sync
);

  localparam int               IDX_W    = (N_SEGS > 1) ? $clog2(N_SEGS) : 1;
  localparam logic [DIV_W-1:0] CNT_TERM = DIV_W'(DIV_TERM);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_SEGS - 1);

  logic [DIV_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                ghost_q, ghost_d;
  logic [7*N_SEGS-1:0] shadow_q, shadow_d;
  logic                load_pend_q, load_pend_d;
  logic                frame_sync_q, frame_sync_d;
  logic                tick;
  logic                load;
  logic                ovf_blank;

  assign tick = (cnt_q == CNT_TERM);
  // A frame wrap and the pending post-reset load share one snapshot path.
  assign load = load_pend_q | (tick & (idx_q == IDX_LAST));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      ghost_q      <= 1'b1;
      shadow_q     <= '1;
      load_pend_q  <= 1'b1;
      frame_sync_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      ghost_q      <= ghost_d;
      shadow_q     <= shadow_d;
      load_pend_q  <= load_pend_d;
      frame_sync_q <= frame_sync_d;
    end
  end

  always_comb begin
    cnt_d        = tick ? '0 : cnt_q + 1'b1;
    idx_d        = idx_q;
    if (tick) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    ghost_d      = tick;
    shadow_d     = load ? segs_in : shadow_q;
    load_pend_d  = 1'b0;
    frame_sync_d = load;
  end

`ifdef SEG_SCAN_OVF_BLINK_EN
  logic       ovf_q;
  logic [4:0] frame_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else if (load) begin
      ovf_q       <= overflow;
      frame_cnt_q <= frame_cnt_q + 5'd1;
    end
  end

  assign ovf_blank = ovf_q & frame_cnt_q[4];
`else
  logic unused_overflow;
  assign unused_overflow = overflow;
  assign ovf_blank       = 1'b0;
`endif

  always_comb begin
    seg_out    = 7'h7F;
    an_out     = '1;
    frame_sync = frame_sync_q;
    if (!ghost_q) begin
      an_out  = ~(N_SEGS'(1) << idx_q);
      seg_out = ovf_blank ? 7'h7F : shadow_q[7*idx_q +: 7];
    end
  end

endmodule
